// File: rtl/i2c_target.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_target (plus helper debouncer)
//  Brief    : I2C target on open-drain SCL/SDA. Decodes START/STOP and the
//             address byte, stores up to 4 written bytes, returns up to 4
//             host-supplied bytes on reads, and reports each completed
//             addressed transaction with a one-cycle pulse. Never stretches
//             SCL.
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Glitch filter: the output follows the input only after the input has
// differed from the output for FILTER_SIZE consecutive cycles.
// ----------------------------------------------------------------------------
module debouncer #(
    parameter logic DEFAULT     = 1'b1,
    parameter int   FILTER_SIZE = 1
) (
    input  logic clk,
    input  logic asyn_rst_n,
    input  logic i_din,
    output logic o_dout
);

    localparam int c_CNT_W = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;

    logic [c_CNT_W-1:0] r_cnt;

    // Count consecutive disagreeing samples; adopt the input once enough seen
    always_ff @(posedge clk or negedge asyn_rst_n) begin
        if (!asyn_rst_n) begin
            o_dout <= DEFAULT;
            r_cnt  <= '0;
        end else if (i_din == o_dout) begin
            r_cnt <= '0;
        end else if (r_cnt == c_CNT_W'(FILTER_SIZE - 1)) begin
            o_dout <= i_din;
            r_cnt  <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h42
) (
    input  logic        clk,
    input  logic        asyn_rst_n,
    input  logic        scl_i,
    output logic        scl_o,
    input  logic        sda_i,
    output logic        sda_o,
    input  logic [31:0] host_tx_data_i,
    output logic [31:0] host_rx_data_o,
    output logic [2:0]  host_rx_cnt_o,
    output logic        host_rx_valid_o,
    output logic        host_rd_done_o,
    output logic        host_busy_o,
    output logic        host_error_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_ACK_A  = 3'd2,
        S_WDATA  = 3'd3,
        S_ACK_W  = 3'd4,
        S_RDATA  = 3'd5,
        S_ACK_R  = 3'd6,
        S_IGNORE = 3'd7
    } state_t;

    // ------------------------------------------------------------------------
    // Input conditioning: bit 1 carries SCL, bit 0 carries SDA
    // ------------------------------------------------------------------------
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] w_db;
    logic [1:0] r_cur;
    logic [1:0] r_prev;

    // Two-flop synchronizers for both pads (bus idles high)
    always_ff @(posedge clk or negedge asyn_rst_n) begin
        if (!asyn_rst_n) begin
            r_sync1 <= 2'b11;
            r_sync2 <= 2'b11;
        end else begin
            r_sync1 <= {scl_i, sda_i};
            r_sync2 <= r_sync1;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_deb
            debouncer #(
                .DEFAULT     (1'b1),
                .FILTER_SIZE (1)
            ) u_deb (
                .clk        (clk),
                .asyn_rst_n (asyn_rst_n),
                .i_din      (r_sync2[gi]),
                .o_dout     (w_db[gi])
            );
        end
    endgenerate

    // History flops: edges and bus conditions come from r_cur versus r_prev
    always_ff @(posedge clk or negedge asyn_rst_n) begin
        if (!asyn_rst_n) begin
            r_cur  <= 2'b11;
            r_prev <= 2'b11;
        end else begin
            r_cur  <= w_db;
            r_prev <= r_cur;
        end
    end

    logic w_sda;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_scl_high;
    logic w_start;
    logic w_stop;

    assign w_sda      = r_cur[0];
    assign w_scl_rise =  r_cur[1] & ~r_prev[1];
    assign w_scl_fall = ~r_cur[1] &  r_prev[1];
    // SCL must be steadily high, so an SCL and SDA edge arriving together
    // (e.g. right after reset) is never mistaken for START/STOP.
    assign w_scl_high =  r_cur[1] &  r_prev[1];
    assign w_start    = w_scl_high &  r_prev[0] & ~r_cur[0];
    assign w_stop     = w_scl_high & ~r_prev[0] &  r_cur[0];

    // ------------------------------------------------------------------------
    // Protocol state
    // ------------------------------------------------------------------------
    state_t      r_state,     w_state_nxt;
    logic [2:0]  r_bit_cnt,   w_bit_cnt_nxt;
    logic        r_bits_done, w_bits_done_nxt;   // 8 bits seen, awaiting fall
    logic [1:0]  r_byte_cnt,  w_byte_cnt_nxt;    // read byte index
    logic [2:0]  r_wr_cnt,    w_wr_cnt_nxt;      // bytes stored this write
    logic [7:0]  r_shift,     w_shift_nxt;
    logic        r_rw,        w_rw_nxt;
    logic        r_ack,       w_ack_nxt;
    logic        r_active,    w_active_nxt;      // addressed txn to report
    logic [31:0] r_tx_buf,    w_tx_buf_nxt;
    logic        r_sda,       w_sda_nxt;
    logic        r_busy,      w_busy_nxt;
    logic        r_error,     w_error_nxt;
    logic [31:0] r_rx_data,   w_rx_data_nxt;
    logic [2:0]  r_rx_cnt,    w_rx_cnt_nxt;
    logic        r_rx_valid,  w_rx_valid_nxt;
    logic        r_rd_done,   w_rd_done_nxt;

    logic [1:0]  w_byte_inc;
    logic        w_mid_byte;

    assign w_byte_inc = r_byte_cnt + 2'd1;

    // A STOP or repeated START always begins with one SCL rise in the data
    // phase, so a single sampled bit in WDATA is normal; more is a cut byte.
    // In RDATA the master has no business ending the transfer at all.
    assign w_mid_byte = ((r_state == S_WDATA) && (r_bits_done || (r_bit_cnt > 3'd1))) ||
                        ((r_state == S_RDATA) && (r_bits_done || (r_bit_cnt != 3'd0)));

    // State and datapath register
    always_ff @(posedge clk or negedge asyn_rst_n) begin
        if (!asyn_rst_n) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= 3'd0;
            r_bits_done <= 1'b0;
            r_byte_cnt  <= 2'd0;
            r_wr_cnt    <= 3'd0;
            r_shift     <= 8'd0;
            r_rw        <= 1'b0;
            r_ack       <= 1'b0;
            r_active    <= 1'b0;
            r_tx_buf    <= 32'd0;
            r_sda       <= 1'b1;
            r_busy      <= 1'b0;
            r_error     <= 1'b0;
            r_rx_data   <= 32'd0;
            r_rx_cnt    <= 3'd0;
            r_rx_valid  <= 1'b0;
            r_rd_done   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_bits_done <= w_bits_done_nxt;
            r_byte_cnt  <= w_byte_cnt_nxt;
            r_wr_cnt    <= w_wr_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_rw        <= w_rw_nxt;
            r_ack       <= w_ack_nxt;
            r_active    <= w_active_nxt;
            r_tx_buf    <= w_tx_buf_nxt;
            r_sda       <= w_sda_nxt;
            r_busy      <= w_busy_nxt;
            r_error     <= w_error_nxt;
            r_rx_data   <= w_rx_data_nxt;
            r_rx_cnt    <= w_rx_cnt_nxt;
            r_rx_valid  <= w_rx_valid_nxt;
            r_rd_done   <= w_rd_done_nxt;
        end
    end

    // Next-state, bit/byte sequencing and host reporting
    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_bits_done_nxt = r_bits_done;
        w_byte_cnt_nxt  = r_byte_cnt;
        w_wr_cnt_nxt    = r_wr_cnt;
        w_shift_nxt     = r_shift;
        w_rw_nxt        = r_rw;
        w_ack_nxt       = r_ack;
        w_active_nxt    = r_active;
        w_tx_buf_nxt    = r_tx_buf;
        w_sda_nxt       = r_sda;
        w_busy_nxt      = r_busy;
        w_error_nxt     = r_error;
        w_rx_data_nxt   = r_rx_data;
        w_rx_cnt_nxt    = r_rx_cnt;
        w_rx_valid_nxt  = 1'b0;
        w_rd_done_nxt   = 1'b0;

        if (w_start || w_stop) begin
            // Close out an addressed transaction before anything else
            if (r_active) begin
                if (r_rw) begin
                    w_rd_done_nxt = 1'b1;
                end else begin
                    w_rx_valid_nxt = 1'b1;
                    w_rx_cnt_nxt   = r_wr_cnt;
                end
                if (w_mid_byte) begin
                    w_error_nxt = 1'b1;
                end
            end
            w_active_nxt    = 1'b0;
            w_sda_nxt       = 1'b1;
            w_bit_cnt_nxt   = 3'd0;
            w_bits_done_nxt = 1'b0;
            if (w_start) begin
                // Busy is held across a repeated START and settled by the
                // address decision that follows.
                w_state_nxt = S_ADDR;
            end else begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        end else begin
            case (r_state)
                S_IDLE, S_IGNORE: begin
                    w_sda_nxt = 1'b1;
                end

                S_ADDR, S_WDATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = {r_shift[6:0], w_sda};
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_bits_done_nxt = 1'b1;
                        end
                    end else if (w_scl_fall && r_bits_done) begin
                        w_bits_done_nxt = 1'b0;
                        if (r_state == S_ADDR) begin
                            if (r_shift[7:1] == TARGET_ADDR) begin
                                w_state_nxt    = S_ACK_A;
                                w_sda_nxt      = 1'b0;
                                w_rw_nxt       = r_shift[0];
                                w_busy_nxt     = 1'b1;
                                w_active_nxt   = 1'b1;
                                w_error_nxt    = 1'b0;
                                w_byte_cnt_nxt = 2'd0;
                                w_wr_cnt_nxt   = 3'd0;
                                if (r_shift[0]) begin
                                    w_tx_buf_nxt = host_tx_data_i;
                                end
                            end else begin
                                w_state_nxt = S_IGNORE;
                                w_busy_nxt  = 1'b0;
                            end
                        end else if (!r_wr_cnt[2]) begin
                            // First byte of a new write replaces the old record
                            if (r_wr_cnt == 3'd0) begin
                                w_rx_data_nxt = {24'd0, r_shift};
                            end else begin
                                w_rx_data_nxt[{r_wr_cnt[1:0], 3'b000} +: 8] = r_shift;
                            end
                            w_wr_cnt_nxt = r_wr_cnt + 3'd1;
                            w_sda_nxt    = 1'b0;
                            w_state_nxt  = S_ACK_W;
                        end else begin
                            // Buffer full: NACK and keep what was stored
                            w_error_nxt = 1'b1;
                            w_state_nxt = S_IGNORE;
                        end
                    end
                end

                S_ACK_A: begin
                    if (w_scl_fall) begin
                        w_bit_cnt_nxt = 3'd0;
                        if (r_rw) begin
                            w_sda_nxt   = r_tx_buf[7];
                            w_state_nxt = S_RDATA;
                        end else begin
                            w_sda_nxt   = 1'b1;
                            w_state_nxt = S_WDATA;
                        end
                    end
                end

                S_ACK_W: begin
                    if (w_scl_fall) begin
                        w_sda_nxt   = 1'b1;
                        w_state_nxt = S_WDATA;
                    end
                end

                S_RDATA: begin
                    if (w_scl_rise) begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_bits_done_nxt = 1'b1;
                        end
                    end else if (w_scl_fall) begin
                        if (r_bits_done) begin
                            w_bits_done_nxt = 1'b0;
                            w_sda_nxt       = 1'b1;
                            w_state_nxt     = S_ACK_R;
                        end else begin
                            // Bit counter counts up, so ~count is the MSB-first index
                            w_sda_nxt = r_tx_buf[{r_byte_cnt, ~r_bit_cnt}];
                        end
                    end
                end

                S_ACK_R: begin
                    if (w_scl_rise) begin
                        w_ack_nxt = ~w_sda;
                    end else if (w_scl_fall) begin
                        if (r_ack) begin
                            w_byte_cnt_nxt = w_byte_inc;
                            w_bit_cnt_nxt  = 3'd0;
                            w_sda_nxt      = r_tx_buf[{w_byte_inc, 3'b111}];
                            w_state_nxt    = S_RDATA;
                        end else begin
                            w_sda_nxt   = 1'b1;
                            w_state_nxt = S_IGNORE;
                        end
                    end
                end

                default: begin
                    w_state_nxt = S_IDLE;
                    w_sda_nxt   = 1'b1;
                end
            endcase
        end
    end

    assign scl_o           = 1'b1;
    assign sda_o           = r_sda;
    assign host_rx_data_o  = r_rx_data;
    assign host_rx_cnt_o   = r_rx_cnt;
    assign host_rx_valid_o = r_rx_valid;
    assign host_rd_done_o  = r_rd_done;
    assign host_busy_o     = r_busy;
    assign host_error_o    = r_error;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_target
//  Brief    : Directed bench for i2c_target with a bit-banged bus master.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_target;

    localparam int c_Q = 10;   // clk cycles per quarter SCL period
    localparam int c_L = 4;    // pad-to-event latency

    logic        clk = 1'b0;
    logic        asyn_rst_n = 1'b0;
    logic        m_scl = 1'b1;
    logic        m_sda = 1'b1;
    logic        scl_o;
    logic        sda_o;
    logic [31:0] host_tx_data_i = 32'd0;
    logic [31:0] host_rx_data_o;
    logic [2:0]  host_rx_cnt_o;
    logic        host_rx_valid_o;
    logic        host_rd_done_o;
    logic        host_busy_o;
    logic        host_error_o;
    logic        w_sda_bus;
    logic        w_scl_bus;

    assign w_sda_bus = m_sda & sda_o;
    assign w_scl_bus = m_scl & scl_o;

    always #5 clk = ~clk;

    i2c_target #(.TARGET_ADDR(7'h42)) dut (
        .clk             (clk),
        .asyn_rst_n      (asyn_rst_n),
        .scl_i           (w_scl_bus),
        .scl_o           (scl_o),
        .sda_i           (w_sda_bus),
        .sda_o           (sda_o),
        .host_tx_data_i  (host_tx_data_i),
        .host_rx_data_o  (host_rx_data_o),
        .host_rx_cnt_o   (host_rx_cnt_o),
        .host_rx_valid_o (host_rx_valid_o),
        .host_rd_done_o  (host_rd_done_o),
        .host_busy_o     (host_busy_o),
        .host_error_o    (host_error_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor state
    int          cyc = 0;
    int          n_rxv = 0;
    int          n_rdd = 0;
    int          n_sda_low = 0;
    int          n_busy = 0;
    int          cyc_rxv = 0;
    int          cyc_rdd = 0;
    logic [2:0]  cap_cnt = 3'd0;
    logic [31:0] cap_data = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (host_rx_valid_o) begin
            n_rxv    <= n_rxv + 1;
            cap_cnt  <= host_rx_cnt_o;
            cap_data <= host_rx_data_o;
            cyc_rxv  <= cyc;
        end
        if (host_rd_done_o) begin
            n_rdd   <= n_rdd + 1;
            cyc_rdd <= cyc;
        end
        if (!sda_o) n_sda_low <= n_sda_low + 1;
        if (host_busy_o) n_busy <= n_busy + 1;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // ---------------- bus master primitives ----------------
    task automatic wait_q();
        repeat (c_Q) @(negedge clk);
    endtask

    task automatic bus_start();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic bus_rstart(output int t);
        m_sda = 1'b1; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b0; t = cyc; wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic bus_stop(output int t);
        m_sda = 1'b0; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b1; t = cyc;
        wait_q(); wait_q(); wait_q();
    endtask

    task automatic bus_bit(input logic b, output logic s);
        m_sda = b;    wait_q();
        m_scl = 1'b1; wait_q();
        s = w_sda_bus; wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
        bus_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            d[i] = s;
        end
        bus_bit(~mack, s);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({sda_o, scl_o} !== 2'b11) begin
            n_fail++; $display("FAIL reset_pads: got %b required 11", {sda_o, scl_o});
        end
        n_checks++;
        if (host_rx_data_o !== 32'd0 || host_rx_cnt_o !== 3'd0) begin
            n_fail++; $display("FAIL reset_rx: got data %h cnt %0d required 0/0", host_rx_data_o, host_rx_cnt_o);
        end
        n_checks++;
        if ({host_rx_valid_o, host_rd_done_o, host_busy_o, host_error_o} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b required 0000",
                {host_rx_valid_o, host_rd_done_o, host_busy_o, host_error_o});
        end
        asyn_rst_n = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if ({sda_o, host_busy_o, host_rx_valid_o} !== 3'b100) begin
            n_fail++; $display("FAIL reset_release: got %b required 100", {sda_o, host_busy_o, host_rx_valid_o});
        end
    endtask

    task automatic test_write3();
        logic       ack;
        logic [3:0] acks;
        int         rxv0, rdd0, t;
        rxv0 = n_rxv; rdd0 = n_rdd;
        bus_start();
        write_byte(8'h84, ack); acks[3] = ack;
        n_checks++;
        if (host_busy_o !== 1'b1) begin
            n_fail++; $display("FAIL wr3_busy: got %b required 1", host_busy_o);
        end
        write_byte(8'h11, ack); acks[2] = ack;
        write_byte(8'h22, ack); acks[1] = ack;
        write_byte(8'h33, ack); acks[0] = ack;
        bus_stop(t);
        n_checks++;
        if (acks !== 4'b1111) begin
            n_fail++; $display("FAIL wr3_acks: got %b required 1111", acks);
        end
        n_checks++;
        if (n_rxv - rxv0 !== 1 || n_rdd - rdd0 !== 0) begin
            n_fail++; $display("FAIL wr3_pulses: got rxv %0d rdd %0d required 1/0", n_rxv - rxv0, n_rdd - rdd0);
        end
        n_checks++;
        if (cap_data !== 32'h00332211 || cap_cnt !== 3'd3) begin
            n_fail++; $display("FAIL wr3_data: got %h cnt %0d required 00332211 cnt 3", cap_data, cap_cnt);
        end
        n_checks++;
        if (cyc_rxv - t !== c_L + 1) begin
            n_fail++; $display("FAIL wr3_latency: got %0d required %0d", cyc_rxv - t, c_L + 1);
        end
        n_checks++;
        if ({host_error_o, host_busy_o} !== 2'b00) begin
            n_fail++; $display("FAIL wr3_flags: got %b required 00", {host_error_o, host_busy_o});
        end
    endtask

    task automatic test_addr_mismatch();
        logic ack;
        int   rxv0, rdd0, low0, busy0, t;
        rxv0 = n_rxv; rdd0 = n_rdd; low0 = n_sda_low; busy0 = n_busy;
        bus_start();
        write_byte(8'h86, ack);
        n_checks++;
        if (ack !== 1'b0) begin
            n_fail++; $display("FAIL mis_nack: got ack %b required 0", ack);
        end
        write_byte(8'h55, ack);
        bus_stop(t);
        n_checks++;
        if (n_sda_low - low0 !== 0 || n_busy - busy0 !== 0) begin
            n_fail++; $display("FAIL mis_quiet: got sda_low %0d busy %0d required 0/0", n_sda_low - low0, n_busy - busy0);
        end
        n_checks++;
        if (n_rxv - rxv0 !== 0 || n_rdd - rdd0 !== 0) begin
            n_fail++; $display("FAIL mis_pulses: got rxv %0d rdd %0d required 0/0", n_rxv - rxv0, n_rdd - rdd0);
        end
        n_checks++;
        if (host_rx_data_o !== 32'h00332211) begin
            n_fail++; $display("FAIL mis_data_kept: got %h required 00332211", host_rx_data_o);
        end
    endtask

    task automatic test_overflow();
        logic       ack;
        logic [5:0] acks;
        int         rxv0, t;
        rxv0 = n_rxv;
        bus_start();
        write_byte(8'h84, ack); acks[5] = ack;
        for (int i = 1; i <= 5; i++) begin
            write_byte(8'(i), ack);
            acks[5 - i] = ack;
        end
        n_checks++;
        if (acks !== 6'b111110) begin
            n_fail++; $display("FAIL ovf_acks: got %b required 111110", acks);
        end
        n_checks++;
        if (host_error_o !== 1'b1) begin
            n_fail++; $display("FAIL ovf_error: got %b required 1", host_error_o);
        end
        bus_stop(t);
        n_checks++;
        if (n_rxv - rxv0 !== 1 || cap_cnt !== 3'd4 || cap_data !== 32'h04030201) begin
            n_fail++; $display("FAIL ovf_report: got pulses %0d cnt %0d data %h required 1/4/04030201",
                n_rxv - rxv0, cap_cnt, cap_data);
        end
        n_checks++;
        if ({host_error_o, host_busy_o} !== 2'b10) begin
            n_fail++; $display("FAIL ovf_after_stop: got %b required 10", {host_error_o, host_busy_o});
        end
    endtask

    task automatic test_read4();
        logic        ack;
        logic [7:0]  b0, b1, b2, b3;
        int          rxv0, rdd0, t;
        rxv0 = n_rxv; rdd0 = n_rdd;
        host_tx_data_i = 32'hDEADBEEF;
        bus_start();
        write_byte(8'h85, ack);
        n_checks++;
        if (ack !== 1'b1 || host_error_o !== 1'b0) begin
            n_fail++; $display("FAIL rd4_addr: got ack %b error %b required 1/0", ack, host_error_o);
        end
        host_tx_data_i = 32'h12345678;
        read_byte(1'b1, b0);
        read_byte(1'b1, b1);
        read_byte(1'b1, b2);
        read_byte(1'b0, b3);
        bus_stop(t);
        n_checks++;
        if ({b3, b2, b1, b0} !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL rd4_bytes: got %h required deadbeef", {b3, b2, b1, b0});
        end
        n_checks++;
        if (n_rdd - rdd0 !== 1 || n_rxv - rxv0 !== 0) begin
            n_fail++; $display("FAIL rd4_pulses: got rdd %0d rxv %0d required 1/0", n_rdd - rdd0, n_rxv - rxv0);
        end
        n_checks++;
        if (cyc_rdd - t !== c_L + 1) begin
            n_fail++; $display("FAIL rd4_latency: got %0d required %0d", cyc_rdd - t, c_L + 1);
        end
        n_checks++;
        if ({sda_o, host_busy_o} !== 2'b10) begin
            n_fail++; $display("FAIL rd4_idle: got %b required 10", {sda_o, host_busy_o});
        end
    endtask

    task automatic test_read_wrap_rstart();
        logic       ack;
        logic [7:0] b;
        logic [7:0] b4, b5;
        int         rxv0, rdd0, t;
        rxv0 = n_rxv; rdd0 = n_rdd;
        host_tx_data_i = 32'hDEADBEEF;
        bus_start();
        write_byte(8'h85, ack);
        for (int i = 0; i < 4; i++) read_byte(1'b1, b);
        read_byte(1'b1, b4);
        read_byte(1'b0, b5);
        n_checks++;
        if ({b4, b5} !== 16'hEFBE) begin
            n_fail++; $display("FAIL wrap_bytes: got %h required efbe", {b4, b5});
        end
        bus_rstart(t);
        write_byte(8'h84, ack);
        n_checks++;
        if (n_rdd - rdd0 !== 1 || n_rxv - rxv0 !== 0 || cyc_rdd - t !== c_L + 1) begin
            n_fail++; $display("FAIL rs_rd_done: got rdd %0d rxv %0d lat %0d required 1/0/%0d",
                n_rdd - rdd0, n_rxv - rxv0, cyc_rdd - t, c_L + 1);
        end
        n_checks++;
        if ({ack, host_busy_o} !== 2'b11) begin
            n_fail++; $display("FAIL rs_addr: got ack/busy %b required 11", {ack, host_busy_o});
        end
        write_byte(8'h5A, ack);
        bus_stop(t);
        n_checks++;
        if (n_rxv - rxv0 !== 1 || cap_cnt !== 3'd1 || cap_data[7:0] !== 8'h5A) begin
            n_fail++; $display("FAIL rs_write: got pulses %0d cnt %0d data %h required 1/1/5a",
                n_rxv - rxv0, cap_cnt, cap_data[7:0]);
        end
    endtask

    task automatic test_async_reset();
        logic       ack, s;
        logic [7:0] pat;
        int         rxv0, rdd0, t;
        rxv0 = n_rxv; rdd0 = n_rdd;
        pat = 8'hC3;
        bus_start();
        write_byte(8'h84, ack);
        write_byte(8'hA1, ack);
        for (int i = 7; i >= 5; i--) bus_bit(pat[i], s);
        n_checks++;
        if (host_rx_data_o[7:0] !== 8'hA1 || host_busy_o !== 1'b1) begin
            n_fail++; $display("FAIL arst_pre: got data %h busy %b required a1/1", host_rx_data_o[7:0], host_busy_o);
        end
        asyn_rst_n = 1'b0;
        #1;
        n_checks++;
        if (host_rx_data_o !== 32'd0 || host_rx_cnt_o !== 3'd0 ||
            {sda_o, host_busy_o, host_error_o, host_rx_valid_o, host_rd_done_o} !== 5'b10000) begin
            n_fail++; $display("FAIL arst_outputs: got data %h cnt %0d flags %b required 0/0/10000",
                host_rx_data_o, host_rx_cnt_o,
                {sda_o, host_busy_o, host_error_o, host_rx_valid_o, host_rd_done_o});
        end
        repeat (3) @(negedge clk);
        asyn_rst_n = 1'b1;
        for (int i = 4; i >= 0; i--) bus_bit(pat[i], s);
        bus_bit(1'b1, s);
        n_checks++;
        if (s !== 1'b1) begin
            n_fail++; $display("FAIL arst_no_ack: got bus %b required 1", s);
        end
        bus_stop(t);
        n_checks++;
        if (n_rxv - rxv0 !== 0 || n_rdd - rdd0 !== 0) begin
            n_fail++; $display("FAIL arst_pulses: got rxv %0d rdd %0d required 0/0", n_rxv - rxv0, n_rdd - rdd0);
        end
        bus_start();
        write_byte(8'h84, ack);
        write_byte(8'h77, ack);
        write_byte(8'h88, ack);
        bus_stop(t);
        n_checks++;
        if (n_rxv - rxv0 !== 1 || cap_cnt !== 3'd2 || cap_data !== 32'h00008877) begin
            n_fail++; $display("FAIL arst_rewrite: got pulses %0d cnt %0d data %h required 1/2/00008877",
                n_rxv - rxv0, cap_cnt, cap_data);
        end
    endtask

    initial begin
        test_reset();
        test_write3();
        test_addr_mismatch();
        test_overflow();
        test_read4();
        test_read_wrap_rstart();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
